// File: rtl/bird_pkg.sv
// bird_pkg -- shared types and constants for the bird_motion block.
//   state_e     : game state (IDLE, PLAY, DEAD)
//   ROW_W       : width of the bird row
//   ROW_MAX     : bottom row index
//   START_ROW   : row held while idle and restored on reset
//   clamp_rise  : row minus rise, saturating at row 0
package bird_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DEAD = 2'd2
    } state_e;

    localparam int unsigned ROW_W     = 4;
    localparam int unsigned ROW_MAX   = 15;
    localparam int unsigned START_ROW = 7;

    typedef logic [ROW_W-1:0] row_t;

    // Subtract one bit wider than the row so a large rise cannot wrap;
    // the extra top bit is the borrow and selects the clamp to 0.
    function automatic row_t clamp_rise(row_t row, row_t rise);
        logic [ROW_W:0] diff;
        diff = {1'b0, row} - {1'b0, rise};
        return diff[ROW_W] ? '0 : diff[ROW_W-1:0];
    endfunction

endpackage

// File: rtl/bird_motion_if.sv
// bird_motion_if -- game-step strobe, player key and bird status bundle.
//   tick     : one-cycle game-step strobe
//   flap     : player key level, synchronous to clk
//   bird_row : current bird row, 0 = top, 15 = bottom
//   playing  : high while the game is running
//   dead     : high after the bird hit the floor (or ceiling, if enabled)
// Modports: master drives tick/flap and observes status; slave is the block.
interface bird_motion_if;
    import bird_pkg::*;

    logic tick;
    logic flap;
    row_t bird_row;
    logic playing;
    logic dead;

    modport master (
        output tick,
        output flap,
        input  bird_row,
        input  playing,
        input  dead
    );

    modport slave (
        input  tick,
        input  flap,
        output bird_row,
        output playing,
        output dead
    );

endinterface

// File: rtl/bird_motion_edge_detect.sv
// edge_detect -- rising-edge detector for the flap key.
//   clk   : system clock
//   reset : synchronous active-high reset
//   in    : level input (already synchronous)
//   rise  : high for the single cycle in which in goes 0 -> 1
// A level that is high while reset is released is not treated as an edge;
// the input must first be seen low.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic prev_q, prev_d;
    logic armed_q, armed_d;

    always_comb begin
        prev_d  = in;
        armed_d = armed_q | ~in;
    end

    // armed_q captures whether the input was low during reset, so a key
    // held through reset release stays disarmed until it drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= 1'b0;
            armed_q <= ~in;
        end else begin
            prev_q  <= prev_d;
            armed_q <= armed_d;
        end
    end

    assign rise = in & ~prev_q & armed_q;

endmodule

// File: rtl/bird_motion.sv
// bird_motion -- vertical motion of the bird in a flappy-style game.
//   clk   : system clock, all logic on posedge
//   reset : synchronous active-high reset
//   bus   : bird_motion_if.slave (tick, flap in; bird_row, playing, dead out)
// Parameters:
//   FLAP_RISE      : rows gained per applied flap (1..15)
//   TICKS_PER_FALL : ticks without a flap before falling one row (1..15)
// Build option:
//   BIRD_CEILING_KILL_EN : a flap that would lift the bird above row 0 puts
//                          it at row 0 and kills it; undefined, the row clamps
//                          at 0 and play continues.
module bird_motion
    import bird_pkg::*;
#(
    parameter int unsigned FLAP_RISE      = 2,
    parameter int unsigned TICKS_PER_FALL = 2
) (
    input  logic          clk,
    input  logic          reset,
    bird_motion_if.slave  bus
);

    localparam row_t       RISE_ROWS = row_t'(FLAP_RISE);
    localparam logic [3:0] FALL_LAST = 4'(TICKS_PER_FALL - 1);

    state_e     state_q, state_d;
    row_t       row_q, row_d;
    logic       pend_q, pend_d;
    logic [3:0] fall_cnt_q, fall_cnt_d;
    logic       flap_ev;

    edge_detect u_flap_edge (
        .clk   (clk),
        .reset (reset),
        .in    (bus.flap),
        .rise  (flap_ev)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            row_q      <= row_t'(START_ROW);
            pend_q     <= 1'b0;
            fall_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            pend_q     <= pend_d;
            fall_cnt_q <= fall_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        pend_d     = pend_q;
        fall_cnt_d = fall_cnt_q;

        unique case (state_q)
            IDLE: begin
                // The starting flap is consumed here; a coincident tick is dropped.
                row_d      = row_t'(START_ROW);
                pend_d     = 1'b0;
                fall_cnt_d = '0;
                if (flap_ev) begin
                    state_d = PLAY;
                end
            end

            PLAY: begin
                if (bus.tick) begin
                    if (pend_q || flap_ev) begin
                        pend_d     = 1'b0;
                        fall_cnt_d = '0;
`ifdef BIRD_CEILING_KILL_EN
                        if (row_q < RISE_ROWS) begin
                            row_d   = '0;
                            state_d = DEAD;
                        end else begin
                            row_d = clamp_rise(row_q, RISE_ROWS);
                        end
`else
                        row_d = clamp_rise(row_q, RISE_ROWS);
`endif
                    end else if (fall_cnt_q == FALL_LAST) begin
                        fall_cnt_d = '0;
                        if (row_q == row_t'(ROW_MAX)) begin
                            state_d = DEAD;
                        end else begin
                            row_d = row_q + row_t'(1);
                        end
                    end else begin
                        fall_cnt_d = fall_cnt_q + 4'd1;
                    end
                end else if (flap_ev) begin
                    pend_d = 1'b1;
                end
            end

            DEAD: begin
                // Everything frozen until reset.
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.bird_row = row_q;
        bus.playing  = (state_q == PLAY);
        bus.dead     = (state_q == DEAD);
    end

endmodule

// File: tb/tb_bird_motion.sv
module tb_bird_motion;

    localparam int FR  = 2;
    localparam int TPF = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bird_motion_if bus ();

    bird_motion #(
        .FLAP_RISE      (FR),
        .TICKS_PER_FALL (TPF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: game described directly from the rules.
    int m_row;
    bit m_playing;
    bit m_dead;
    bit m_pending;
    int m_quiet;
    bit m_prev;
    bit m_block;

    function automatic void model_step(bit t, bit f, bit r);
        bit ev;
        if (r) begin
            m_row     = 7;
            m_playing = 0;
            m_dead    = 0;
            m_pending = 0;
            m_quiet   = 0;
            m_prev    = 0;
            m_block   = f;
            return;
        end
        ev = f && !m_prev && !m_block;
        if (!f) m_block = 0;
        m_prev = f;
        if (m_dead) return;
        if (!m_playing) begin
            if (ev) m_playing = 1;
            return;
        end
        if (t) begin
            if (m_pending || ev) begin
                m_pending = 0;
                m_quiet   = 0;
`ifdef BIRD_CEILING_KILL_EN
                if (m_row < FR) begin
                    m_row     = 0;
                    m_dead    = 1;
                    m_playing = 0;
                end else begin
                    m_row = m_row - FR;
                end
`else
                m_row = (m_row - FR < 0) ? 0 : m_row - FR;
`endif
            end else begin
                m_quiet++;
                if (m_quiet == TPF) begin
                    m_quiet = 0;
                    if (m_row == 15) begin
                        m_dead    = 1;
                        m_playing = 0;
                    end else begin
                        m_row++;
                    end
                end
            end
        end else if (ev) begin
            m_pending = 1;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit t, input bit f, input bit r);
        bus.tick  = t;
        bus.flap  = f;
        reset     = r;
        model_step(t, f, r);
        @(posedge clk);
        #1;
        check("row_vs_model",     32'(bus.bird_row), 32'(m_row));
        check("playing_vs_model", 32'(bus.playing),  32'(m_playing));
        check("dead_vs_model",    32'(bus.dead),     32'(m_dead));
    endtask

    initial begin
        bit fcur;
        bus.tick = 1'b0;
        bus.flap = 1'b0;
        reset    = 1'b1;

        // Reset state
        step(0, 0, 1);
        step(0, 0, 1);
        check("rst_row",     32'(bus.bird_row), 7);
        check("rst_playing", 32'(bus.playing),  0);
        check("rst_dead",    32'(bus.dead),     0);
        step(0, 0, 0);

        // Idle ignores ticks
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0);
            step(0, 0, 0);
        end
        check("idle_row",     32'(bus.bird_row), 7);
        check("idle_playing", 32'(bus.playing),  0);
        check("idle_dead",    32'(bus.dead),     0);

        // Start, then gravity on every second tick
        step(0, 1, 0);
        step(0, 0, 0);
        check("start_playing", 32'(bus.playing),  1);
        check("start_row",     32'(bus.bird_row), 7);
        begin
            int exp_rows [4] = '{7, 8, 8, 9};
            for (int i = 0; i < 4; i++) begin
                step(1, 0, 0);
                check("fall_row", 32'(bus.bird_row), 32'(exp_rows[i]));
                step(0, 0, 0);
            end
        end

        // Held key across three ticks rises exactly once
        for (int i = 0; i < 50; i++) begin
            step((i == 10) || (i == 25) || (i == 40), 1, 0);
            if (i == 10) check("held_rise_row", 32'(bus.bird_row), 7);
            if (i == 25) check("held_no_rerise", 32'(bus.bird_row), 7);
        end
        step(0, 0, 0);
        check("held_after_row", 32'(bus.bird_row), 8);

        // Fall to the floor and die
        for (int i = 0; i < 14; i++) begin
            step(1, 0, 0);
            step(0, 0, 0);
        end
        check("floor_row",     32'(bus.bird_row), 15);
        check("floor_playing", 32'(bus.playing),  1);
        step(1, 0, 0);
        check("floor_tick1_dead", 32'(bus.dead), 0);
        step(1, 0, 0);
        check("floor_dead",    32'(bus.dead),     1);
        check("floor_playing0", 32'(bus.playing), 0);
        check("floor_row15",   32'(bus.bird_row), 15);
        for (int i = 0; i < 8; i++) begin
            step(i[0], i[1], 0);
        end
        step(0, 0, 0);
        check("dead_frozen_row",  32'(bus.bird_row), 15);
        check("dead_frozen_dead", 32'(bus.dead),     1);

        // Reset wins over tick and flap edge in DEAD
        step(1, 1, 1);
        check("dead_rst_row",  32'(bus.bird_row), 7);
        check("dead_rst_dead", 32'(bus.dead),     0);
        check("dead_rst_play", 32'(bus.playing),  0);
        // Key held through reset release is not an event
        for (int i = 0; i < 3; i++) step(1, 1, 0);
        check("held_reset_no_start", 32'(bus.playing), 0);
        step(0, 0, 0);
        step(0, 1, 0);
        check("rearm_start", 32'(bus.playing), 1);
        step(0, 0, 0);

        // Rise to the ceiling
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0);
            step(0, 0, 0);
            step(1, 0, 0);
        end
        check("climb_row", 32'(bus.bird_row), 1);
        step(0, 1, 0);
        step(1, 0, 0);
        check("ceiling_row", 32'(bus.bird_row), 0);
`ifdef BIRD_CEILING_KILL_EN
        check("ceiling_dead", 32'(bus.dead),    1);
`else
        check("ceiling_play", 32'(bus.playing), 1);
`endif

        // Start flap coincident with tick: tick not applied
        step(0, 0, 1);
        step(0, 0, 0);
        step(1, 1, 0);
        check("start_tick_playing", 32'(bus.playing),  1);
        check("start_tick_row",     32'(bus.bird_row), 7);
        step(1, 0, 0);
        check("start_tick_cnt1", 32'(bus.bird_row), 7);
        step(1, 0, 0);
        check("start_tick_cnt2", 32'(bus.bird_row), 8);

        // Random traffic against the model
        fcur = 0;
        for (int i = 0; i < 3000; i++) begin
            bit r, t;
            r = ($urandom_range(199) == 0);
            t = ($urandom_range(2) == 0);
            if ($urandom_range(3) == 0) fcur = ~fcur;
            step(t, fcur, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
